// File: rtl/conv_bridge.sv
// conv_bridge: bridges an upstream dav_/rfd producer handshake to a downstream
// soc/eoc converter handshake through a 2-entry FIFO.
//
// Ports:
//   clock    in   system clock, all state changes on the rising edge
//   reset_   in   synchronous active-low reset
//   dav_in_  in   upstream data-valid, active low
//   d_in     in   upstream data byte, valid while dav_in_ = 0
//   rfd_out  out  ready-for-data to upstream, active high
//   soc      in   start-of-conversion from downstream
//   eoc      out  end-of-conversion, 1 = idle or result ready
//   x        out  result byte, held from pop until the next pop
//   count    out  number of buffered bytes, 0..2
module conv_bridge (
    input  logic       clock,
    input  logic       reset_,
    input  logic       dav_in_,
    input  logic [7:0] d_in,
    output logic       rfd_out,
    input  logic       soc,
    output logic       eoc,
    output logic [7:0] x,
    output logic [1:0] count
);

    typedef enum logic {
        StIdleIn,
        StWaitDav
    } in_state_e;

    typedef enum logic [1:0] {
        StIdleOut,
        StWaitSocLow,
        StWaitData,
        StSettle
    } out_state_e;

    in_state_e  in_state_q, in_state_d;
    out_state_e out_state_q, out_state_d;

    logic [7:0] mem_q [2];
    logic       wr_ptr_q;
    logic       rd_ptr_q;
    logic [1:0] count_q, count_d;
    logic [7:0] x_q;
    logic       push;
    logic       pop;

    // Input side: a byte is taken only when there is room before the edge,
    // so a full FIFO never accepts, even if it is popped at the same edge.
    always_comb begin
        in_state_d = in_state_q;
        push       = 1'b0;
        unique case (in_state_q)
            StIdleIn: begin
                if (!dav_in_ && (count_q < 2'd2)) begin
                    push       = 1'b1;
                    in_state_d = StWaitDav;
                end
            end
            StWaitDav: begin
                if (dav_in_) begin
                    in_state_d = StIdleIn;
                end
            end
        endcase
    end

    // Output side: x is loaded on the pop, then SETTLE gives it one full cycle
    // before eoc rises.
    always_comb begin
        out_state_d = out_state_q;
        pop         = 1'b0;
        unique case (out_state_q)
            StIdleOut: begin
                if (soc) out_state_d = StWaitSocLow;
            end
            StWaitSocLow: begin
                if (!soc) out_state_d = StWaitData;
            end
            StWaitData: begin
                if (count_q != 2'd0) begin
                    pop         = 1'b1;
                    out_state_d = StSettle;
                end
            end
            StSettle: begin
                out_state_d = StIdleOut;
            end
        endcase
    end

    // push is never raised at count 2 and pop never at count 0, so this
    // stays within 0..2.
    assign count_d = count_q + {1'b0, push} - {1'b0, pop};

    always_ff @(posedge clock) begin
        if (!reset_) begin
            in_state_q  <= StIdleIn;
            out_state_q <= StIdleOut;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            count_q     <= 2'd0;
            x_q         <= 8'h00;
            for (int i = 0; i < 2; i++) begin
                mem_q[i] <= 8'h00;
            end
        end else begin
            in_state_q  <= in_state_d;
            out_state_q <= out_state_d;
            count_q     <= count_d;
            if (push) begin
                mem_q[wr_ptr_q] <= d_in;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                x_q      <= mem_q[rd_ptr_q];
                rd_ptr_q <= ~rd_ptr_q;
            end
        end
    end

    assign rfd_out = (in_state_q == StIdleIn);
    assign eoc     = (out_state_q == StIdleOut);
    assign x       = x_q;
    assign count   = count_q;

endmodule

// File: tb/tb_conv_bridge.sv
// tb_conv_bridge: directed and randomized checks of conv_bridge against a
// queue-based behavioural model of the two handshakes and the FIFO.
module tb_conv_bridge;

    logic       clock = 1'b0;
    logic       reset_;
    logic       dav_in_;
    logic [7:0] d_in;
    logic       rfd_out;
    logic       soc;
    logic       eoc;
    logic [7:0] x;
    logic [1:0] count;

    always #5 clock = ~clock;

    conv_bridge dut (
        .clock   (clock),
        .reset_  (reset_),
        .dav_in_ (dav_in_),
        .d_in    (d_in),
        .rfd_out (rfd_out),
        .soc     (soc),
        .eoc     (eoc),
        .x       (x),
        .count   (count)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: FIFO as a queue, producer readiness as a bit, and the
    // converter handshake as a phase number (0 idle, 1 soc high seen,
    // 2 waiting for data, 3 result settling).
    logic [7:0] m_q [$];
    bit         m_rfd   = 1'b1;
    int         m_phase = 0;
    logic [7:0] m_x     = 8'h00;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        int sz;
        bit do_push;
        bit do_pop;
        sz = m_q.size();
        if (!reset_) begin
            m_q.delete();
            m_rfd   = 1'b1;
            m_phase = 0;
            m_x     = 8'h00;
        end else begin
            do_push = m_rfd && !dav_in_ && (sz < 2);
            do_pop  = (m_phase == 2) && (sz > 0);
            if (do_pop) m_x = m_q.pop_front();
            if (do_push) m_q.push_back(d_in);
            if (m_rfd && do_push) m_rfd = 1'b0;
            else if (!m_rfd && dav_in_) m_rfd = 1'b1;
            case (m_phase)
                0: if (soc) m_phase = 1;
                1: if (!soc) m_phase = 2;
                2: if (do_pop) m_phase = 3;
                default: m_phase = 0;
            endcase
        end
    endtask

    // One clock edge: advance the model on the inputs present before the edge,
    // then compare all outputs 1 time unit after it.
    task automatic tick();
        model_edge();
        @(posedge clock);
        #1;
        check("rfd_out", {7'b0, rfd_out}, {7'b0, m_rfd});
        check("eoc", {7'b0, eoc}, {7'b0, (m_phase == 0)});
        check("x", x, m_x);
        check("count", {6'b0, count}, m_q.size());
    endtask

    task automatic push_byte(input logic [7:0] b);
        d_in    = b;
        dav_in_ = 1'b0;
        tick();
        dav_in_ = 1'b1;
        tick();
    endtask

    // Full soc pulse, then wait (bounded) for eoc to return.
    task automatic soc_cycle();
        soc = 1'b1;
        tick();
        soc = 1'b0;
        tick();
        for (int i = 0; i < 40 && m_phase != 0; i++) tick();
        check("soc_cycle_done", {7'b0, eoc}, 8'd1);
    endtask

    initial begin
        reset_  = 1'b0;
        dav_in_ = 1'b1;
        d_in    = 8'h00;
        soc     = 1'b0;
        #2;

        // Reset state
        tick();
        check("rst_rfd", {7'b0, rfd_out}, 8'd1);
        check("rst_eoc", {7'b0, eoc}, 8'd1);
        check("rst_x", x, 8'h00);
        check("rst_count", {6'b0, count}, 8'd0);
        reset_ = 1'b1;

        // Single transfer
        push_byte(8'hA5);
        check("single_count1", {6'b0, count}, 8'd1);
        soc = 1'b1;
        tick();
        check("single_eoc_low", {7'b0, eoc}, 8'd0);
        soc = 1'b0;
        tick();
        tick();
        check("single_x", x, 8'hA5);
        check("single_eoc_still_low", {7'b0, eoc}, 8'd0);
        tick();
        check("single_eoc_high", {7'b0, eoc}, 8'd1);
        check("single_count0", {6'b0, count}, 8'd0);

        // Empty FIFO: converter waits indefinitely
        soc = 1'b1;
        tick();
        soc = 1'b0;
        tick();
        for (int i = 0; i < 20; i++) begin
            tick();
            check("empty_wait_eoc", {7'b0, eoc}, 8'd0);
        end
        d_in    = 8'h3C;
        dav_in_ = 1'b0;
        tick();
        dav_in_ = 1'b1;
        tick();
        check("empty_x", x, 8'h3C);
        check("empty_eoc_low", {7'b0, eoc}, 8'd0);
        tick();
        check("empty_eoc_high", {7'b0, eoc}, 8'd1);

        // Full FIFO
        push_byte(8'h11);
        push_byte(8'h22);
        d_in    = 8'h33;
        dav_in_ = 1'b0;
        tick();
        check("full_rfd", {7'b0, rfd_out}, 8'd1);
        check("full_count", {6'b0, count}, 8'd2);
        soc_cycle();
        check("full_x1", x, 8'h11);
        check("full_accept_33", {7'b0, rfd_out}, 8'd0);
        dav_in_ = 1'b1;
        tick();
        soc_cycle();
        check("full_x2", x, 8'h22);
        soc_cycle();
        check("full_x3", x, 8'h33);
        check("full_drained", {6'b0, count}, 8'd0);

        // Simultaneous push and pop at count 1
        push_byte(8'h77);
        soc = 1'b1;
        tick();
        soc = 1'b0;
        tick();
        d_in    = 8'h44;
        dav_in_ = 1'b0;
        tick();
        check("pp_x", x, 8'h77);
        check("pp_count", {6'b0, count}, 8'd1);
        dav_in_ = 1'b1;
        tick();
        tick();
        soc_cycle();
        check("pp_next", x, 8'h44);

        // Mid-operation reset with one byte buffered and eoc low
        soc = 1'b1;
        tick();
        soc = 1'b0;
        tick();
        tick();
        d_in    = 8'h66;
        dav_in_ = 1'b0;
        tick();
        check("mid_count1", {6'b0, count}, 8'd1);
        check("mid_eoc_low", {7'b0, eoc}, 8'd0);
        reset_  = 1'b0;
        dav_in_ = 1'b1;
        tick();
        check("mid_rst_eoc", {7'b0, eoc}, 8'd1);
        check("mid_rst_count", {6'b0, count}, 8'd0);
        check("mid_rst_x", x, 8'h00);
        reset_ = 1'b1;
        soc    = 1'b1;
        tick();
        soc = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("mid_fresh_wait", {7'b0, eoc}, 8'd0);
        end
        push_byte(8'h99);
        tick();
        check("mid_fresh_x", x, 8'h99);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            reset_  = ($urandom_range(0, 299) != 0);
            dav_in_ = $urandom_range(0, 2) == 0;
            soc     = $urandom_range(0, 3) == 0;
            d_in    = 8'($urandom);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
